// File: rtl/mips_run_ctrl_pkg.sv
// Purpose : shared types and constants for the MIPS run/debug sequencer.
//           State encoding, halt cause codes and the BREAK instruction fields.
// Ports   : none (package).
package mips_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLR,
      ST_RUN,
      ST_STEP,
      ST_HALT
   } state_e;

   typedef enum logic [2:0] {
      CAUSE_NONE = 3'd0,
      CAUSE_EXT  = 3'd1,
      CAUSE_BRK  = 3'd2,
      CAUSE_BP   = 3'd3,
      CAUSE_WDT  = 3'd4
   } cause_e;

   localparam logic [5:0] OPC_SPECIAL = 6'h00;
   localparam logic [5:0] FUNCT_BREAK = 6'h0D;

endpackage

// File: rtl/mips_run_ctrl_if.sv
// Purpose : host/core-facing bundle of the run controller.
// Ports   : master = debug host + core side (drives controls, PC, Instr),
//           slave  = mips_run_ctrl (drives CoreEnable/CoreReset and status).
interface mips_run_ctrl_if #(
   parameter int ADDR_W = 32,
   parameter int CNT_W  = 32
);
   logic              start;
   logic              restart;
   logic              step;
   logic              stop;
   logic              break_en;
   logic [ADDR_W-1:0] break_addr;
   logic [ADDR_W-1:0] pc_addr;
   logic [31:0]       instr;
   logic              core_enable;
   logic              core_reset;
   logic              halted;
   logic [2:0]        halt_cause;
   logic [CNT_W-1:0]  instr_count;

   modport master (
      output start, restart, step, stop, break_en, break_addr, pc_addr, instr,
      input  core_enable, core_reset, halted, halt_cause, instr_count
   );

   modport slave (
      input  start, restart, step, stop, break_en, break_addr, pc_addr, instr,
      output core_enable, core_reset, halted, halt_cause, instr_count
   );
endinterface

// File: rtl/mips_run_ctrl_halt_detect.sv
// Purpose : combinational halt-condition decode for the run controller.
// Ports   : i_opcode/i_funct  fields of the fetched instruction
//           i_pc, i_break_addr, i_break_en, i_skip  breakpoint match inputs
//           i_count           committed-instruction count (watchdog)
//           i_stop            external halt request
//           o_brk/o_bp/o_wdt  individual conditions, o_halt_now any of them
//           o_cause           highest-priority cause: EXT > BRK > BP > WDT
module run_halt_detect
   import mips_ctrl_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int CNT_W    = 32,
   parameter int WATCHDOG = 0
) (
   input  logic [5:0]        i_opcode,
   input  logic [5:0]        i_funct,
   input  logic [ADDR_W-1:0] i_pc,
   input  logic [ADDR_W-1:0] i_break_addr,
   input  logic              i_break_en,
   input  logic              i_skip,
   input  logic [CNT_W-1:0]  i_count,
   input  logic              i_stop,
   output logic              o_brk,
   output logic              o_bp,
   output logic              o_wdt,
   output logic              o_halt_now,
   output cause_e            o_cause
);

   assign o_brk      = (i_opcode == OPC_SPECIAL) && (i_funct == FUNCT_BREAK);
   // skip lets a resume execute the instruction sitting on the breakpoint
   assign o_bp       = i_break_en && (i_pc == i_break_addr) && !i_skip;
   assign o_wdt      = (WATCHDOG != 0) && (i_count == CNT_W'(WATCHDOG));
   assign o_halt_now = i_stop || o_brk || o_bp || o_wdt;

   always_comb begin
      o_cause = CAUSE_NONE;
      if (i_stop)     o_cause = CAUSE_EXT;
      else if (o_brk) o_cause = CAUSE_BRK;
      else if (o_bp)  o_cause = CAUSE_BP;
      else if (o_wdt) o_cause = CAUSE_WDT;
   end

endmodule

// File: rtl/mips_run_ctrl.sv
// Purpose : run/debug sequencer for the single-cycle MIPS core. Gates core
//           commit through CoreEnable, holds the core in reset while idle or
//           clearing, and halts on stop, BREAK, PC breakpoint or watchdog.
// Ports   : i_clock  rising-edge clock
//           i_reset  synchronous, active-low
//           bus      slave side of mips_run_ctrl_if (controls in, status out)
//
// state   | meaning
// IDLE    | core held in reset, waiting for Start
// CLR     | one cycle: clear count/cause/skip, core still in reset
// RUN     | free running, commit unless a halt condition is present
// STEP    | one cycle: commit one instruction (unless BREAK), then HALT
// HALT    | no commits; Restart > Start > Step
module mips_run_ctrl
   import mips_ctrl_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int CNT_W    = 32,
   parameter int WATCHDOG = 0
) (
   input  logic        i_clock,
   input  logic        i_reset,
   mips_run_ctrl_if.slave bus
);

   state_e           r_state;
   cause_e           r_cause;
   logic             r_skip;
   logic             r_halted;
   logic [CNT_W-1:0] r_count;

   logic             w_brk;
   logic             w_bp;
   logic             w_wdt;
   logic             w_halt_now;
   cause_e           w_cause;
   logic             w_core_enable;

   run_halt_detect #(
      .ADDR_W   (ADDR_W),
      .CNT_W    (CNT_W),
      .WATCHDOG (WATCHDOG)
   ) u_detect (
      .i_opcode     (bus.instr[31:26]),
      .i_funct      (bus.instr[5:0]),
      .i_pc         (bus.pc_addr),
      .i_break_addr (bus.break_addr),
      .i_break_en   (bus.break_en),
      .i_skip       (r_skip),
      .i_count      (r_count),
      .i_stop       (bus.stop),
      .o_brk        (w_brk),
      .o_bp         (w_bp),
      .o_wdt        (w_wdt),
      .o_halt_now   (w_halt_now),
      .o_cause      (w_cause)
   );

   // Commit decision is combinational so the halting instruction itself is
   // never committed; a reset cycle never commits.
   always_comb begin
      w_core_enable = 1'b0;
      if (i_reset) begin
         case (r_state)
            ST_RUN:  w_core_enable = !w_halt_now;
            ST_STEP: w_core_enable = !w_brk;
            default: w_core_enable = 1'b0;
         endcase
      end
   end

   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         r_state  <= ST_IDLE;
         r_cause  <= CAUSE_NONE;
         r_skip   <= 1'b0;
         r_halted <= 1'b0;
         r_count  <= '0;
      end else begin
         if (w_core_enable && (r_count != {CNT_W{1'b1}}))
            r_count <= r_count + 1'b1;
         case (r_state)
            ST_IDLE: begin
               if (bus.start) r_state <= ST_CLR;
            end
            ST_CLR: begin
               r_count <= '0;
               r_cause <= CAUSE_NONE;
               r_skip  <= 1'b0;
               r_state <= ST_RUN;
            end
            ST_RUN: begin
               if (w_halt_now) begin
                  r_state  <= ST_HALT;
                  r_cause  <= w_cause;
                  r_halted <= 1'b1;
               end else begin
                  r_skip <= 1'b0;
               end
            end
            ST_STEP: begin
               r_state  <= ST_HALT;
               r_halted <= 1'b1;
               if (w_brk) r_cause <= CAUSE_BRK;
            end
            ST_HALT: begin
               if (bus.restart) begin
                  r_state  <= ST_CLR;
                  r_halted <= 1'b0;
               end else if (bus.start) begin
                  r_state  <= ST_RUN;
                  r_skip   <= 1'b1;
                  r_halted <= 1'b0;
               end else if (bus.step) begin
                  r_state  <= ST_STEP;
                  r_halted <= 1'b0;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.core_enable = w_core_enable;
   assign bus.core_reset  = (r_state == ST_IDLE) || (r_state == ST_CLR);
   assign bus.halted      = r_halted;
   assign bus.halt_cause  = r_cause;
   assign bus.instr_count = r_count;

   // bp and wdt are folded into halt_now/cause; kept as named nets for debug
   logic w_unused;
   assign w_unused = w_bp ^ w_wdt;

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Bench for mips_run_ctrl. Two instances: dut_a (no watchdog, 32-bit count)
// and dut_w (WATCHDOG=5, 3-bit count to reach saturation). A tiny core model
// per instance advances PC by 4 (wrapping at 0x40) whenever CoreEnable is 1
// and returns it to 0 while CoreReset is 1.
module tb_mips_run_ctrl;

   localparam logic [31:0] BRK = 32'h0000_000D;

   typedef struct {
      bit          w;
      bit          rst;
      bit          st;
      bit          rs;
      bit          sp;
      bit          so;
      bit          be;
      logic [31:0] instr;
      bit          ce;
      bit          cr;
      bit          hl;
      logic [2:0]  c;
      logic [31:0] n;
      logic [31:0] pc;
   } vec_t;

   typedef struct {
      bit          ce;
      bit          cr;
      bit          hl;
      logic [2:0]  c;
      logic [31:0] n;
      logic [31:0] pc;
   } exp_t;

   logic clk;
   logic rst_a;
   logic rst_w;
   int   n_chk;
   int   n_pass;
   vec_t vecs[$];
   exp_t sb[$];

   mips_run_ctrl_if #(.ADDR_W(32), .CNT_W(32)) ifa ();
   mips_run_ctrl_if #(.ADDR_W(32), .CNT_W(3))  ifw ();

   mips_run_ctrl #(.ADDR_W(32), .CNT_W(32), .WATCHDOG(0)) dut_a (
      .i_clock (clk),
      .i_reset (rst_a),
      .bus     (ifa.slave)
   );

   mips_run_ctrl #(.ADDR_W(32), .CNT_W(3), .WATCHDOG(5)) dut_w (
      .i_clock (clk),
      .i_reset (rst_w),
      .bus     (ifw.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) begin
      if (!rst_a || ifa.core_reset) ifa.pc_addr <= '0;
      else if (ifa.core_enable)     ifa.pc_addr <= (ifa.pc_addr + 32'd4) & 32'h3F;
   end

   always @(posedge clk) begin
      if (!rst_w || ifw.core_reset) ifw.pc_addr <= '0;
      else if (ifw.core_enable)     ifw.pc_addr <= (ifw.pc_addr + 32'd4) & 32'h3F;
   end

   task automatic add(input bit w, input bit rst, input bit st, input bit rs,
                      input bit sp, input bit so, input bit be, input logic [31:0] instr,
                      input bit ce, input bit cr, input bit hl, input int c,
                      input int n, input int pc);
      vec_t v;
      v.w = w; v.rst = rst; v.st = st; v.rs = rs; v.sp = sp; v.so = so; v.be = be;
      v.instr = instr; v.ce = ce; v.cr = cr; v.hl = hl;
      v.c = 3'(c); v.n = 32'(n); v.pc = 32'(pc);
      vecs.push_back(v);
   endtask

   task automatic chk(input int idx, input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL v%0d %s: got %h want %h", idx, nm, act, exp);
   endtask

   task automatic apply(input int idx, input vec_t v);
      exp_t e;
      exp_t g;
      @(negedge clk);
      rst_a = v.w ? 1'b0 : v.rst;
      rst_w = v.w ? v.rst : 1'b0;
      ifa.start   = v.w ? 1'b0 : v.st;
      ifa.restart = v.w ? 1'b0 : v.rs;
      ifa.step    = v.w ? 1'b0 : v.sp;
      ifa.stop    = v.w ? 1'b0 : v.so;
      ifa.break_en = v.w ? 1'b0 : v.be;
      ifa.instr   = v.w ? 32'h0 : v.instr;
      ifw.start   = v.w ? v.st : 1'b0;
      ifw.restart = v.w ? v.rs : 1'b0;
      ifw.step    = v.w ? v.sp : 1'b0;
      ifw.stop    = v.w ? v.so : 1'b0;
      ifw.break_en = v.w ? v.be : 1'b0;
      ifw.instr   = v.w ? v.instr : 32'h0;
      e.ce = v.ce; e.cr = v.cr; e.hl = v.hl; e.c = v.c; e.n = v.n; e.pc = v.pc;
      sb.push_back(e);
      #1;
      if (sb.size() == 0) begin
         n_chk++;
         $display("FAIL v%0d scoreboard: got empty want entry", idx);
      end else begin
         g = sb.pop_front();
         if (!v.w) begin
            chk(idx, "core_enable", 32'(ifa.core_enable), 32'(g.ce));
            chk(idx, "core_reset",  32'(ifa.core_reset),  32'(g.cr));
            chk(idx, "halted",      32'(ifa.halted),      32'(g.hl));
            chk(idx, "halt_cause",  32'(ifa.halt_cause),  32'(g.c));
            chk(idx, "instr_count", ifa.instr_count,      g.n);
            chk(idx, "pc",          ifa.pc_addr,          g.pc);
         end else begin
            chk(idx, "w_core_enable", 32'(ifw.core_enable), 32'(g.ce));
            chk(idx, "w_core_reset",  32'(ifw.core_reset),  32'(g.cr));
            chk(idx, "w_halted",      32'(ifw.halted),      32'(g.hl));
            chk(idx, "w_halt_cause",  32'(ifw.halt_cause),  32'(g.c));
            chk(idx, "w_instr_count", 32'(ifw.instr_count), g.n);
            chk(idx, "w_pc",          ifw.pc_addr,          g.pc);
         end
      end
   endtask

   initial begin
      n_chk = 0;
      n_pass = 0;
      rst_a = 1'b0;
      rst_w = 1'b0;
      ifa.start = 0; ifa.restart = 0; ifa.step = 0; ifa.stop = 0; ifa.break_en = 0;
      ifa.instr = 32'h0; ifa.break_addr = 32'h20;
      ifw.start = 0; ifw.restart = 0; ifw.step = 0; ifw.stop = 0; ifw.break_en = 0;
      ifw.instr = 32'h0; ifw.break_addr = 32'h20;

      // reset, start, free run, BREAK at 0x10
      add(0,0,0,0,0,0,0,0,   0,1,0,0,0,0);
      add(0,0,0,0,0,0,0,0,   0,1,0,0,0,0);
      add(0,1,1,0,0,0,0,0,   0,1,0,0,0,0);
      add(0,1,0,0,0,0,0,0,   0,1,0,0,0,0);
      for (int i = 0; i < 4; i++) add(0,1,0,0,0,0,0,0, 1,0,0,0,i,4*i);
      add(0,1,0,0,0,0,0,BRK, 0,0,0,0,4,'h10);
      add(0,1,0,0,0,0,0,BRK, 0,0,1,2,4,'h10);
      add(0,1,0,0,0,1,0,BRK, 0,0,1,2,4,'h10);
      // Start with Stop in HALT: Start wins; then external stop
      add(0,1,1,0,0,1,0,0,   0,0,1,2,4,'h10);
      add(0,1,0,0,0,0,0,0,   1,0,0,2,4,'h10);
      add(0,1,0,0,0,1,0,0,   0,0,0,2,5,'h14);
      add(0,1,0,0,0,0,0,0,   0,0,1,1,5,'h14);
      // three single steps
      for (int k = 0; k < 3; k++) begin
         add(0,1,0,0,1,0,0,0, 0,0,1,1,5+k,'h14+4*k);
         add(0,1,0,0,0,0,0,0, 1,0,0,1,5+k,'h14+4*k);
      end
      // step onto BREAK: no commit, cause BRK
      add(0,1,0,0,1,0,0,0,   0,0,1,1,8,'h20);
      add(0,1,0,0,0,0,0,BRK, 0,0,0,1,8,'h20);
      add(0,1,0,0,0,0,0,0,   0,0,1,2,8,'h20);
      // Restart (with Start and Step): CLR then run from PC 0
      add(0,1,1,1,1,0,0,0,   0,0,1,2,8,'h20);
      add(0,1,0,0,0,0,0,0,   0,1,0,2,8,'h20);
      for (int i = 0; i < 8; i++) add(0,1,0,0,0,0,1,0, 1,0,0,0,i,4*i);
      // breakpoint at 0x20, resume past it, hit it again after wrap
      add(0,1,0,0,0,0,1,0,   0,0,0,0,8,'h20);
      add(0,1,1,0,0,0,1,0,   0,0,1,3,8,'h20);
      add(0,1,0,0,0,0,1,0,   1,0,0,3,8,'h20);
      for (int k = 0; k < 15; k++) add(0,1,0,0,0,0,1,0, 1,0,0,3,9+k,(36+4*k)&63);
      add(0,1,0,0,0,0,1,0,   0,0,0,3,24,'h20);
      add(0,1,1,0,0,0,1,0,   0,0,1,3,24,'h20);
      add(0,1,0,0,0,0,1,0,   1,0,0,3,24,'h20);
      // reset mid-RUN
      add(0,0,0,0,0,1,1,0,   0,0,0,3,25,'h24);
      add(0,1,0,0,0,0,1,0,   0,1,0,0,0,0);
      add(0,1,0,1,1,0,1,0,   0,1,0,0,0,0);

      // watchdog instance: 5 commits, steps to saturation, Stop+BREAK
      add(1,0,0,0,0,0,0,0,   0,1,0,0,0,0);
      add(1,0,0,0,0,0,0,0,   0,1,0,0,0,0);
      add(1,1,1,0,0,0,0,0,   0,1,0,0,0,0);
      add(1,1,0,0,0,0,0,0,   0,1,0,0,0,0);
      for (int i = 0; i < 5; i++) add(1,1,0,0,0,0,0,0, 1,0,0,0,i,4*i);
      add(1,1,0,0,0,0,0,0,   0,0,0,0,5,'h14);
      for (int k = 0; k < 3; k++) begin
         add(1,1,0,0,1,0,0,0, 0,0,1,4,5+k,'h14+4*k);
         add(1,1,0,0,0,0,0,0, 1,0,0,4,5+k,'h14+4*k);
      end
      add(1,1,0,1,0,0,0,0,   0,0,1,4,7,'h20);
      add(1,1,0,0,0,0,0,0,   0,1,0,4,7,'h20);
      add(1,1,0,0,0,1,0,BRK, 0,0,0,0,0,0);
      add(1,1,0,0,0,0,0,0,   0,0,1,1,0,0);

      for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
